example_block_sync_fifo: RTL and testbench
==========================================

Name: example_block_sync_fifo

Overview:
- Parametrised synchronous FIFO with valid/ready handshakes on both sides.
- Data width, depth and almost-full threshold are configurable. The block exposes occupancy and a synchronous software clear.
- Sits between the example_block datapath stages as the standard elastic buffer. Decouples producer and consumer backpressure inside one clock domain.

Parameters:
- DAT_W, 32, data word width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- AFULL_TH, 6, almost-full threshold in entries (1..DEPTH)
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
- clk  input  1  clock signal
- rst_n  input  1  asynchronous active-low reset
- sw_clr  input  1  synchronous clear; flushes all entries
- in_vld  input  1  producer data valid
- in_dat  input  DAT_W  producer data
- in_rdy  output  1  FIFO can accept a word this cycle
- out_vld  output  1  head word valid
- out_dat  output  DAT_W  head word (first-word fall-through)
- out_rdy  input  1  consumer accepts head word
- cnt  output  CNT_W  current occupancy, 0..DEPTH
- full  output  1  cnt == DEPTH
- empty  output  1  cnt == 0
- afull  output  1  cnt >= AFULL_TH

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n.
- Reset values:
  - wr_ptr, rd_ptr and cnt = 0
  - empty=1, full=0, afull=0
  - in_rdy=1, out_vld=0
  - out_dat = 0; storage array is not reset.
- Push: push = in_vld & in_rdy. On push, mem[wr_ptr] <= in_dat and wr_ptr increments.
- Pop: pop = out_vld & out_rdy. On pop, rd_ptr increments.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- cnt update: cnt <= cnt + push - pop.
  - Push and pop in the same cycle leave cnt unchanged.
  - Both pointers still advance.
- in_rdy = !full and out_vld = !empty. Both are combinational from registered cnt, with no combinational path from in_vld or out_rdy.
- Full boundary: in_rdy=0, so no push occurs even if out_rdy=1 in that cycle. Push is allowed again the cycle after the pop.
- Empty boundary: out_vld=0, so no pop occurs. There is no bypass: a word pushed into an empty FIFO appears on out_vld/out_dat the next cycle (latency 1).
- out_dat = mem[rd_ptr] when out_vld=1, and 0 when empty.
  - out_dat must be stable while out_vld=1 and out_rdy=0.
- Overflow and underflow are impossible by construction. The bench asserts that cnt never exceeds DEPTH or wraps below 0.
- sw_clr=1:
  - Next cycle: pointers and cnt = 0, empty=1.
  - Takes priority over any push/pop in the same cycle; those transfers are discarded.
  - in_rdy and out_vld are unaffected in the sw_clr cycle itself (still derived from the current cnt).
- Reset mid-operation: all state returns to reset values immediately on rst_n fall, independent of clk.
- afull, full and empty are derived from cnt with no extra latency.

Test Plan:
- Fill/drain (DEPTH=8, DAT_W=32): push 0x00..0x07 with out_rdy=0.
  - Outputs: cnt=8, full=1, in_rdy=0, afull=1 (from cnt=6).
  - Then out_rdy=1: words pop 0x00..0x07 in order; empty=1 after the 8th pop.
- Latency: push 0xA5A5A5A5 into empty FIFO at cycle N.
  - out_vld=1 and out_dat=0xA5A5A5A5 at N+1; cnt=1.
- Simultaneous push/pop at cnt=4 for 20 cycles with incrementing data.
  - cnt stays 4.
  - Output sequence exactly matches input delayed by 4 transfers.
  - Pointers wrap at least twice.
- Full + out_rdy + in_vld same cycle at cnt=8.
  - Pop occurs, push rejected (in_rdy=0); cnt=7.
  - Next cycle push accepted; cnt=8.
- sw_clr with cnt=5 and concurrent push/pop.
  - Next cycle: cnt=0, empty=1, out_vld=0.
  - Subsequent push 0x11 is the next word out.
- Async reset: assert rst_n=0 mid-cycle at cnt=3.
  - cnt=0, empty=1, in_rdy=1, out_vld=0 immediately without a clk edge.
  - Normal operation resumes after release.

Source files
------------

// File: rtl/example_block_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
// It reports occupancy and almost-full status, and supports a synchronous software clear.
module example_block_sync_fifo #(
  parameter int DAT_W    = 32,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_clr,
  input  logic             in_vld,
  input  logic [DAT_W-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [DAT_W-1:0] out_dat,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty,
  output logic             afull
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_TH);

  logic [DAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             push;
  logic             pop;

  // Status flags come only from the registered count.
  // This keeps in_vld and out_rdy off any combinational path to in_rdy or out_vld.
  assign full    = (cnt_reg == DEPTH_CNT);
  assign empty   = (cnt_reg == '0);
  assign afull   = (cnt_reg >= AFULL_CNT);
  assign in_rdy  = !full;
  assign out_vld = !empty;
  assign cnt     = cnt_reg;

  assign push = in_vld & in_rdy;
  assign pop  = out_vld & out_rdy;

  assign out_dat = empty ? '0 : mem[rd_ptr_reg];

  always_comb begin
    cnt_next = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + CNT_ONE;
      2'b01:   cnt_next = cnt_reg - CNT_ONE;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (sw_clr) begin
      // A clear discards any transfer that is offered in the same cycle.
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      cnt_reg <= cnt_next;
    end
  end

  // Storage has no reset; out_dat is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !sw_clr) mem[wr_ptr_reg] <= in_dat;
  end

endmodule

// File: tb/tb_example_block_sync_fifo.sv
// Directed testbench for example_block_sync_fifo (DEPTH=8, DAT_W=32, AFULL_TH=6).
// Each scenario task drives stimulus and checks the outputs against hand-computed values.
module tb_example_block_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sw_clr = 1'b0;
  logic        in_vld = 1'b0;
  logic [31:0] in_dat = '0;
  logic        in_rdy;
  logic        out_vld;
  logic [31:0] out_dat;
  logic        out_rdy = 1'b0;
  logic [3:0]  cnt;
  logic        full;
  logic        empty;
  logic        afull;

  int errors = 0;
  int checks = 0;

  example_block_sync_fifo #(.DAT_W(32), .DEPTH(8), .AFULL_TH(6)) dut (
    .clk(clk), .rst_n(rst_n), .sw_clr(sw_clr),
    .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_dat(out_dat), .out_rdy(out_rdy),
    .cnt(cnt), .full(full), .empty(empty), .afull(afull)
  );

  always #5 clk = ~clk;

  // Occupancy bounds and flag consistency are checked on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (cnt > 4'd8 || empty !== (cnt == 4'd0) || full !== (cnt == 4'd8) ||
          afull !== (cnt >= 4'd6) || in_rdy !== !(cnt == 4'd8) || out_vld !== !(cnt == 4'd0)) begin
        errors++;
        $display("FAIL monitor_flags: cnt=%0d empty=%b full=%b afull=%b in_rdy=%b out_vld=%b, required cnt<=8 with consistent flags",
                 cnt, empty, full, afull, in_rdy, out_vld);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    in_vld  = 1'b1;
    out_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_dat = base + 32'(i);
      tick();
    end
    in_vld = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cnt, empty, full, afull, in_rdy, out_vld} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d e=%b f=%b af=%b rdy=%b vld=%b, required 0 1 0 0 1 0",
               cnt, empty, full, afull, in_rdy, out_vld);
    end else $display("ok   reset_state");
    check("reset_out_dat", out_dat, 32'h0);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    in_vld  = 1'b1;
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_dat = 32'(i);
      tick();
      check("fill_cnt", 32'(cnt), 32'(i + 1));
      check("fill_afull", 32'(afull), (i + 1 >= 6) ? 32'd1 : 32'd0);
    end
    in_vld = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_in_rdy", 32'(in_rdy), 32'd0);
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_dat", out_dat, 32'(i));
      tick();
    end
    out_rdy = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
  endtask

  task automatic test_latency();
    check("lat_pre_vld", 32'(out_vld), 32'd0);
    in_vld = 1'b1;
    in_dat = 32'hA5A5A5A5;
    tick();
    in_vld = 1'b0;
    check("lat_vld", 32'(out_vld), 32'd1);
    check("lat_dat", out_dat, 32'hA5A5A5A5);
    check("lat_cnt", 32'(cnt), 32'd1);
    tick();
    check("lat_hold_dat", out_dat, 32'hA5A5A5A5);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("lat_pop_empty", 32'(empty), 32'd1);
  endtask

  task automatic test_back_to_back();
    push_words(32'd100, 4);
    check("b2b_start_cnt", 32'(cnt), 32'd4);
    in_vld  = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_dat = 32'd104 + 32'(i);
      check("b2b_dat", out_dat, 32'd100 + 32'(i));
      tick();
      check("b2b_cnt", 32'(cnt), 32'd4);
    end
    in_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b_tail", out_dat, 32'd120 + 32'(i));
      tick();
    end
    out_rdy = 1'b0;
    check("b2b_empty", 32'(empty), 32'd1);
  endtask

  task automatic test_full_boundary();
    push_words(32'd200, 8);
    check("fb_full", 32'(full), 32'd1);
    in_vld  = 1'b1;
    in_dat  = 32'h300;
    out_rdy = 1'b1;
    check("fb_in_rdy", 32'(in_rdy), 32'd0);
    tick();
    check("fb_cnt_after_pop", 32'(cnt), 32'd7);
    out_rdy = 1'b0;
    tick();
    in_vld = 1'b0;
    check("fb_cnt_after_push", 32'(cnt), 32'd8);
    out_rdy = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("fb_drain", out_dat, 32'd200 + 32'(i));
      tick();
    end
    check("fb_last", out_dat, 32'h300);
    tick();
    out_rdy = 1'b0;
    check("fb_empty", 32'(empty), 32'd1);
  endtask

  task automatic test_sw_clr();
    push_words(32'h50, 5);
    check("clr_pre_cnt", 32'(cnt), 32'd5);
    sw_clr  = 1'b1;
    in_vld  = 1'b1;
    in_dat  = 32'h99;
    out_rdy = 1'b1;
    check("clr_cycle_in_rdy", 32'(in_rdy), 32'd1);
    check("clr_cycle_out_vld", 32'(out_vld), 32'd1);
    tick();
    sw_clr  = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    check("clr_cnt", 32'(cnt), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    check("clr_out_vld", 32'(out_vld), 32'd0);
    check("clr_out_dat", out_dat, 32'h0);
    in_vld = 1'b1;
    in_dat = 32'h11;
    tick();
    in_vld = 1'b0;
    check("clr_next_dat", out_dat, 32'h11);
    check("clr_next_cnt", 32'(cnt), 32'd1);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic test_async_reset();
    push_words(32'h60, 3);
    check("ar_pre_cnt", 32'(cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_cnt", 32'(cnt), 32'd0);
    check("ar_empty", 32'(empty), 32'd1);
    check("ar_in_rdy", 32'(in_rdy), 32'd1);
    check("ar_out_vld", 32'(out_vld), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    in_vld = 1'b1;
    in_dat = 32'h77;
    tick();
    in_vld = 1'b0;
    check("ar_resume_dat", out_dat, 32'h77);
    check("ar_resume_cnt", 32'(cnt), 32'd1);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_full_boundary();
    test_sw_clr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units, required completion");
    $fatal(1, "timeout");
  end

endmodule
